// File: rtl/cp0_timer_bank.sv
// Count/Compare timer bank: one prescaled free-running Count and N_CH compare channels
// with one-shot or auto-reload modes, sticky pending flags and an aggregated interrupt.
module cp0_timer_bank #(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned COUNT_W       = 32,
   parameter int unsigned PRESCALE      = 2,
   parameter bit          ZERO_DISABLES = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [4:0]         waddr,
   input  logic [2:0]         wsel,
   input  logic [31:0]        wdata,
   input  logic [4:0]         raddr,
   input  logic [2:0]         rsel,
   output logic [31:0]        rdata,
   input  logic               count_stop,
   output logic [COUNT_W-1:0] count_o,
   output logic [N_CH-1:0]    pending,
   output logic               timer_int
);

   localparam int unsigned     PH_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PH_W-1:0] PH_LAST    = PH_W'(PRESCALE - 1);
   localparam logic [4:0]      ADDR_COUNT = 5'd9;
   localparam logic [4:0]      ADDR_CMP   = 5'd11;
   localparam logic [4:0]      ADDR_CTRL  = 5'd22;
   localparam logic [4:0]      ADDR_PER   = 5'd23;

   logic [COUNT_W-1:0] count_q, count_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic [COUNT_W-1:0] compare_q [N_CH];
   logic [COUNT_W-1:0] compare_d [N_CH];
   logic [COUNT_W-1:0] period_q  [N_CH];
   logic [COUNT_W-1:0] period_d  [N_CH];
   logic [N_CH-1:0]    enable_q, enable_d, periodic_q, periodic_d, pending_q, pending_d;
   logic [N_CH-1:0]    match, match_q, match_edge, cmp_we, per_we, clr;
   logic               count_we, ctrl_we, tick;
   logic               timer_int_q, timer_int_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               unused_wdata;

   assign unused_wdata = ^wdata;

   always_comb begin
      count_we = we && waddr == ADDR_COUNT && wsel == 3'd0;
      ctrl_we  = we && waddr == ADDR_CTRL && wsel == 3'd0;
      for (int i = 0; i < N_CH; i++) begin
         cmp_we[i] = we && waddr == ADDR_CMP && wsel == 3'(i);
         per_we[i] = we && waddr == ADDR_PER && wsel == 3'(i);
         match[i]  = enable_q[i] && count_q == compare_q[i] &&
                     !(ZERO_DISABLES && compare_q[i] == '0);
      end
   end

   // Edge detect gives one event per arrival even while Count dwells on the value.
   assign match_edge = match & ~match_q;
   assign clr        = cmp_we | ({N_CH{ctrl_we}} & wdata[16 +: N_CH]);

   always_comb begin
      tick    = !count_stop && phase_q == PH_LAST;
      phase_d = phase_q;
      if (!count_stop) phase_d = tick ? '0 : phase_q + PH_W'(1);
      count_d = count_q;
      if (count_we)  count_d = wdata[COUNT_W-1:0];
      else if (tick) count_d = count_q + COUNT_W'(1);
   end

   always_comb begin
      enable_d   = enable_q;
      periodic_d = periodic_q;
      if (ctrl_we) begin
         enable_d   = wdata[N_CH-1:0];
         periodic_d = wdata[8 +: N_CH];
      end
      // A new match outranks a simultaneous clear.
      pending_d = match_edge | (pending_q & ~clr);
      for (int i = 0; i < N_CH; i++) begin
         compare_d[i] = compare_q[i];
         period_d[i]  = period_q[i];
         if (cmp_we[i]) begin
            compare_d[i] = wdata[COUNT_W-1:0];
         end else if (match_edge[i] && periodic_q[i] && period_q[i] != '0) begin
            compare_d[i] = compare_q[i] + period_q[i];
         end
         if (per_we[i]) period_d[i] = wdata[COUNT_W-1:0];
      end
      timer_int_d = |(pending_d & enable_d);
   end

   always_comb begin
      rdata_d = '0;
      if (raddr == ADDR_COUNT && rsel == 3'd0) begin
         rdata_d[COUNT_W-1:0] = count_q;
      end
      if (raddr == ADDR_CTRL && rsel == 3'd0) begin
         rdata_d[N_CH-1:0]  = enable_q;
         rdata_d[8 +: N_CH]  = periodic_q;
         rdata_d[16 +: N_CH] = pending_q;
      end
      for (int i = 0; i < N_CH; i++) begin
         if (raddr == ADDR_CMP && rsel == 3'(i)) rdata_d[COUNT_W-1:0] = compare_q[i];
         if (raddr == ADDR_PER && rsel == 3'(i)) rdata_d[COUNT_W-1:0] = period_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         phase_q     <= '0;
         enable_q    <= N_CH'(1);
         periodic_q  <= '0;
         pending_q   <= '0;
         match_q     <= '0;
         timer_int_q <= 1'b0;
         rdata_q     <= '0;
         for (int i = 0; i < N_CH; i++) begin
            compare_q[i] <= '0;
            period_q[i]  <= '0;
         end
      end else begin
         count_q     <= count_d;
         phase_q     <= phase_d;
         enable_q    <= enable_d;
         periodic_q  <= periodic_d;
         pending_q   <= pending_d;
         match_q     <= match;
         timer_int_q <= timer_int_d;
         rdata_q     <= rdata_d;
         for (int i = 0; i < N_CH; i++) begin
            compare_q[i] <= compare_d[i];
            period_q[i]  <= period_d[i];
         end
      end
   end

   assign count_o   = count_q;
   assign pending   = pending_q;
   assign timer_int = timer_int_q;
   assign rdata     = rdata_q;

endmodule

// File: doc/cp0_timer_bank.md
Name: cp0_timer_bank

Overview:
- Parametrised successor to the single Count/Compare timer in cp0.
- Provides one free-running Count with a configurable prescaler and N_CH independent Compare channels. Each channel runs in one-shot or periodic (auto-reload) mode.
- Each channel has a sticky pending flag; the flags are aggregated into timer_int.
- Sits beside cp0 and is accessed through the same WB-stage write request and MFC0-style registered read. timer_int feeds cause.ip[7].

Parameters:
- N_CH, 4, number of compare channels (1..8).
- COUNT_W, 32, Count/Compare/Period width (8..32).
- PRESCALE, 2, Count increments once every PRESCALE cycles (1..256).
- ZERO_DISABLES, 1, when 1 a Compare value of 0 never matches.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- we  in  1  write strobe (WB stage)
- waddr  in  5  write register number
- wsel  in  3  write select
- wdata  in  32  write data
- raddr  in  5  read register number
- rsel  in  3  read select
- rdata  out  32  read data, registered
- count_stop  in  1  freezes Count and prescaler (debug)
- count_o  out  COUNT_W  current Count
- pending  out  N_CH  per-channel sticky match flags
- timer_int  out  1  OR of (pending & enable)

Behaviour:
- Clocking: one clock `clk`; reset `rst` is synchronous, active-high.
- Register map (all other addr/sel combinations read 0 and ignore writes):
  - addr 9 sel 0: Count.
  - addr 11 sel i (i<N_CH): Compare[i].
  - addr 23 sel i (i<N_CH): Period[i].
  - addr 22 sel 0: Ctrl. bits[7:0] enable, bits[15:8] periodic, bits[23:16] pending (read) / write-1-to-clear; bits for channels >= N_CH read 0.
- Width rules: writes truncate to COUNT_W; reads zero-extend to 32.
- Reset values: Count 0, prescaler phase 0, all Compare/Period 0, enable = channel 0 only (cp0-compatible), periodic 0, pending 0, rdata 0, timer_int 0.
- Read path: rdata updates 1 cycle after raddr/rsel are presented (registered). Writes are visible to a read issued in the next cycle.
- Prescaler:
  - Phase counter counts 0..PRESCALE-1; Count += 1 on the cycle the phase equals PRESCALE-1, then the phase wraps to 0.
  - PRESCALE=1 means Count increments every cycle.
  - count_stop holds both Count and phase.
  - Count wraps modulo 2^COUNT_W.
- Count write: takes priority over the increment in the same cycle. Prescaler phase is not reset.
- Match for channel i: enable[i] & (Count == Compare[i]) & !(ZERO_DISABLES & Compare[i]==0), evaluated on registered values.
- match_edge[i] = match[i] & !match_q[i] (match_q is the previous cycle's match). This gives one event per arrival even when Count dwells for PRESCALE cycles.
- On match_edge[i]:
  - pending[i] <= 1 next cycle.
  - If periodic[i] and Period[i]!=0: Compare[i] <= Compare[i] + Period[i] (mod 2^COUNT_W).
  - Period 0 in periodic mode behaves as one-shot.
- Pending clear: a write to Compare[i], or writing 1 to Ctrl bit 16+i, clears pending[i].
- Simultaneous events on the same channel:
  - match_edge and a clear in the same cycle: set wins, pending stays 1.
  - match_edge reload and a software Compare[i] write in the same cycle: the software value wins.
- Disabling: clearing enable[i] masks timer_int contribution and further matches; pending[i] is retained.
- Outputs: timer_int is registered, equal to |(pending & enable) computed from the next-state values, i.e. it asserts 1 cycle after match_edge. pending and count_o are direct register outputs.
- Reset mid-operation returns every register to its reset value in the same cycle; no match is generated from pre-reset state (match_q cleared).

Test Plan:
- Reset values: after rst, read Ctrl -> 0x00000001. Count starts at 0 and increments on every 2nd cycle (PRESCALE=2); timer_int=0.
- One-shot: write Compare[0]=10 -> pending[0] and timer_int go 1 one cycle after Count reaches 10 and stay 1. A Compare[0] write then clears both. Count dwelling 2 cycles at 10 gives no second event.
- Periodic: enable ch1 periodic, Compare[1]=5, Period[1]=7 -> match events at Count 5, 12, 19. Compare[1] reads 12 after the first event. Clearing via Ctrl W1C (wdata=0x00020000) between events drops pending[1].
- Race: W1C of pending[2] in the exact cycle of its match_edge -> pending[2] remains 1. Count write of 100 concurrent with a prescale tick -> Count reads 100, not 101.
- Wrap/zero: COUNT_W=8, Compare[0]=3, periodic, Period=255 -> next Compare = 2 (mod 256), and the match recurs after Count wraps. Compare=0 with ZERO_DISABLES=1 -> no match when Count=0.
- count_stop and reset: assert count_stop for 20 cycles -> Count and phase frozen. Assert rst while pending=0xF -> next cycle pending=0, timer_int=0, rdata=0.
